// File: rtl/u_rec.sv
// u_rec: oversampling UART receiver (8N1, LSB first).
// The line is double-flopped before use. A falling edge starts a frame.
// The start bit is re-checked at its midpoint, which rejects short glitches.
// Data and stop bits are then sampled once per OVERSAMPLE cycles, at bit centre.
module u_rec #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_l,
  input  logic       uart_in,
  output logic [7:0] rec_data,
  output logic       rec_ready,
  output logic       frame_err,
  output logic       rec_busy
);

  // Output handshake: rec_ready is a one-cycle valid strobe with no back-pressure.
  // rec_data changes only on the same edge that raises rec_ready, and holds until
  // the next good frame. frame_err is an independent one-cycle strobe and never
  // coincides with rec_ready.

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic [7:0]      rec_data_nxt;
  logic            ready_nxt, ferr_nxt;
  logic            sync1, sin, sin_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      sync1 <= 1'b1;
      sin   <= 1'b1;
      sin_d <= 1'b1;
    end else begin
      sync1 <= uart_in;
      sin   <= sync1;
      sin_d <= sin;
    end
  end

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rec_data  <= 8'h00;
      rec_ready <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      rec_data  <= rec_data_nxt;
      rec_ready <= ready_nxt;
      frame_err <= ferr_nxt;
    end
  end

  // Next-state logic. The line is only examined at the sample points.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    rec_data_nxt = rec_data;
    ready_nxt    = 1'b0;
    ferr_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (sin_d && !sin) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          if (!sin) begin
            state_nxt   = DATA;
            bit_idx_nxt = 3'd0;
          end else begin
            // The line went back high: treat it as a glitch, not a start bit.
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {sin, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (sin) begin
            rec_data_nxt = shreg;
            ready_nxt    = 1'b1;
            state_nxt    = IDLE;
          end else begin
            // Broken frame: keep the old byte and wait for the line to recover.
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_HI;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_HI: begin
        if (sin) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The receiver is busy whenever the FSM is not in IDLE.
  always_comb begin
    rec_busy = (state != IDLE);
  end

endmodule
